// File: rtl/grant_requester_pkg.sv
// Shared types and sizing for the grant requester and its per-channel logic.
package grant_requester_pkg;

  localparam int N     = 4;
  localparam int LEN_W = 4;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_t;

endpackage

// File: rtl/grant_req_channel.sv
// One requester channel: START is accepted in IDLE, REQ is held for LEN+1 granted beats, then DONE pulses.
// REQ rises 1 cycle after START; a withheld grant simply stalls the burst with state and count frozen.
module grant_req_channel
  import grant_requester_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  len_t len,
  input  logic gnt,
  output logic req,
  output logic done
);

  chan_state_t state_q, state_d;
  len_t        rem_q, rem_d;
  logic        done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          rem_d   = len;
        end
      end
      ACTIVE: begin
        // START is deliberately ignored here, including on the final beat.
        if (gnt) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - len_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req = (state_q == ACTIVE);

endmodule

// File: rtl/grant_requester.sv
// N-channel requester facing a one-hot arbiter; flags multi-hot or unrequested grants as a sticky error.
// REQ/DONE registered per channel, BEAT combinational; channels stall while their grant is withheld.
module grant_requester
  import grant_requester_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] start,
  input  len_t         len,
  input  logic [N-1:0] gnt,
  output logic [N-1:0] req,
  output logic [N-1:0] beat,
  output logic [N-1:0] done,
  output logic [N-1:0] busy,
  output logic         proto_err
);

  logic multi_gnt;
  logic stray_gnt;

  for (genvar i = 0; i < N; i++) begin : g_chan
    grant_req_channel u_chan (
      .clk   (clk),
      .reset (reset),
      .start (start[i]),
      .len   (len),
      .gnt   (gnt[i]),
      .req   (req[i]),
      .done  (done[i])
    );
  end

  assign beat = req & gnt;
  assign busy = req;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_gnt = |(gnt & (gnt - N'(1)));
  assign stray_gnt = |(gnt & ~req);

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (multi_gnt || stray_gnt) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grant_requester.sv
// Bench for grant_requester: directed scenarios plus random traffic against a beats-remaining model.
module tb_grant_requester;
  import grant_requester_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] start;
  len_t         len;
  logic [N-1:0] gnt;
  logic [N-1:0] req, beat, done, busy;
  logic         proto_err;

  int total = 0;
  int bad   = 0;

  // Model: each channel either idle or owing a number of beats.
  bit           m_active[N];
  int           m_left[N];
  logic [N-1:0] m_done = '0;
  logic         m_err  = 1'b0;
  int           m_beats[N];
  int           d_beats[N];

  always #5 clk = ~clk;

  grant_requester dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .gnt       (gnt),
    .req       (req),
    .beat      (beat),
    .done      (done),
    .busy      (busy),
    .proto_err (proto_err)
  );

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_active[i];
    return r;
  endfunction

  function automatic logic [N-1:0] arb(input logic [N-1:0] r);
    return r & (~r + N'(1));
  endfunction

  // Applies inputs just after the falling edge; outputs settle before checking.
  task automatic drive(input logic rst, input logic [N-1:0] st, input len_t ln,
                       input bit frc, input logic [N-1:0] fg);
    reset = rst;
    start = st;
    len   = ln;
    gnt   = frc ? fg : arb(m_req());
    #1;
  endtask

  // Moves the model across the next rising edge, then returns at the falling edge.
  task automatic advance();
    logic [N-1:0] r;
    r = m_req();
    for (int i = 0; i < N; i++) begin
      if (m_active[i] && gnt[i]) m_beats[i]++;
      if (beat[i]) d_beats[i]++;
    end
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_active[i] = 1'b0;
        m_left[i]   = 0;
      end
      m_done = '0;
      m_err  = 1'b0;
    end else begin
      if ((gnt & ~r) != '0 || $countones(gnt) > 1) m_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_done[i] = 1'b0;
        if (m_active[i]) begin
          if (gnt[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_active[i] = 1'b0;
              m_done[i]   = 1'b1;
            end
          end
        end else if (start[i]) begin
          m_active[i] = 1'b1;
          m_left[i]   = int'(len) + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, '1, len_t'(7), 1'b0, '0);
    advance();
    drive(1'b1, '0, '0, 1'b0, '0);
    advance();
    drive(1'b0, '0, '0, 1'b0, '0);
    total++;
    if ({req, busy, done, proto_err} !== {N'(0), N'(0), N'(0), 1'b0}) begin
      bad++;
      $display("FAIL reset: req=%b busy=%b done=%b err=%b, want all zero", req, busy, done, proto_err);
    end
  endtask

  task automatic test_solo(input string tag);
    logic [N-1:0] exp_beat[6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [N-1:0] exp_done[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, (c == 0) ? 4'b0001 : 4'b0000, len_t'(2), 1'b0, '0);
      total++;
      if (beat !== exp_beat[c] || done !== exp_done[c] || req !== (exp_beat[c] | arb(m_req()))) begin
        bad++;
        $display("FAIL %s c%0d: beat=%b done=%b req=%b, want beat=%b done=%b req=%b",
                 tag, c, beat, done, req, exp_beat[c], exp_done[c], exp_beat[c] | arb(m_req()));
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_beat[6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    logic [N-1:0] exp_done[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, (c == 0) ? 4'b0011 : 4'b0000, len_t'(1), 1'b0, '0);
      total++;
      if (beat !== exp_beat[c] || done !== exp_done[c] || req !== m_req()) begin
        bad++;
        $display("FAIL contention c%0d: beat=%b done=%b req=%b, want beat=%b done=%b req=%b",
                 c, beat, done, req, exp_beat[c], exp_done[c], m_req());
      end
      advance();
    end
  endtask

  task automatic test_preemption();
    int ch2 = 0;
    int ch0 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      drive(1'b0, 4'b0100, len_t'(3), 1'b0, '0);
      else if (c == 1) drive(1'b0, 4'b0001, len_t'(0), 1'b0, '0);
      else             drive(1'b0, 4'b0000, len_t'(9), 1'b0, '0);
      ch2 += int'(beat[2]);
      ch0 += int'(beat[0]);
      if (c == 2) begin
        total++;
        if (beat !== 4'b0001) begin
          bad++;
          $display("FAIL preempt_pause: beat=%b, want 0001", beat);
        end
      end
      advance();
    end
    total++;
    if (ch2 !== 4 || ch0 !== 1) begin
      bad++;
      $display("FAIL preempt_count: ch2=%0d ch0=%0d, want ch2=4 ch0=1", ch2, ch0);
    end
  endtask

  task automatic test_busy_start();
    int beats = 0;
    int dones = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c == 0 || c == 2) ? 4'b0010 : 4'b0000, (c == 0) ? len_t'(3) : len_t'(0), 1'b0, '0);
      beats += int'(beat[1]);
      dones += int'(done[1]);
      advance();
    end
    total++;
    if (beats !== 4 || dones !== 1 || proto_err !== 1'b0 || busy !== 4'b0000) begin
      bad++;
      $display("FAIL busy_start: beats=%0d dones=%0d err=%b busy=%b, want 4 1 0 0000",
               beats, dones, proto_err, busy);
    end
  endtask

  task automatic test_proto_err();
    drive(1'b0, '0, '0, 1'b1, 4'b0100);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, '0, 1'b0, '0);
      total++;
      if (proto_err !== 1'b1 || m_err !== 1'b1) begin
        bad++;
        $display("FAIL proto_stray c%0d: err=%b, want 1", c, proto_err);
      end
      advance();
    end
    drive(1'b1, '0, '0, 1'b0, '0);
    advance();
    drive(1'b0, 4'b0011, len_t'(3), 1'b0, '0);
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_cleared: err=%b, want 0", proto_err);
    end
    advance();
    drive(1'b0, '0, '0, 1'b1, 4'b0011);
    total++;
    if (req !== 4'b0011 || beat !== 4'b0011) begin
      bad++;
      $display("FAIL proto_multi_beat: req=%b beat=%b, want 0011 0011", req, beat);
    end
    advance();
    drive(1'b0, '0, '0, 1'b0, '0);
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_multi: err=%b, want 1", proto_err);
    end
    advance();
    drive(1'b1, '0, '0, 1'b0, '0);
    advance();
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 3; c++) begin
      drive(c == 2, (c == 0 || c == 2) ? 4'b0001 : 4'b0000, len_t'(5), 1'b0, '0);
      advance();
    end
    for (int c = 3; c < 7; c++) begin
      drive(1'b0, '0, '0, 1'b0, '0);
      total++;
      if (req !== 4'b0000 || done !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid c%0d: req=%b done=%b, want 0000 0000", c, req, done);
      end
      advance();
    end
    test_solo("solo_after_reset");
  endtask

  task automatic test_random();
    logic [N-1:0] st;
    for (int c = 0; c < 600; c++) begin
      st = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      drive($urandom_range(0, 63) == 0, st, len_t'($urandom_range(0, 15)), 1'b0, '0);
      total++;
      if ({req, busy, beat, done, proto_err} !== {m_req(), m_req(), m_req() & gnt, m_done, m_err}) begin
        bad++;
        $display("FAIL random c%0d: req=%b busy=%b beat=%b done=%b err=%b, want req=%b beat=%b done=%b err=%b",
                 c, req, busy, beat, done, proto_err, m_req(), m_req() & gnt, m_done, m_err);
      end
      advance();
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (d_beats[i] !== m_beats[i]) begin
        bad++;
        $display("FAIL beat_total ch%0d: got %0d, want %0d", i, d_beats[i], m_beats[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    len   = '0;
    gnt   = '0;
    @(negedge clk);
    test_reset();
    test_solo("solo");
    test_contention();
    test_preemption();
    test_busy_start();
    test_proto_err();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
